// File: rtl/mpy_seq.sv
// ---------------------------------------------------------------------------
// mpy_seq
//   Sequential shift-add multiplier. One 2*WIDTH-bit accumulator is iterated
//   once per multiplier bit (LSB first), so a product takes exactly WIDTH
//   cycles after the operands are accepted. Operands may be treated as
//   unsigned or two's-complement, selected per operation by signed_mode.
//   Valid/ready handshakes on both the operand and the result side.
//
// Parameters
//   WIDTH        operand width in bits (>= 2); product is 2*WIDTH bits
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operands a/b/signed_mode are presented
//   in_ready     block can accept operands this cycle (combinational)
//   a            multiplicand
//   b            multiplier
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   out_valid    product is valid
//   out_ready    consumer takes the product this cycle
//   product      full-width a*b
//   busy         high while the multiply is iterating
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mpy_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mult;
   logic                 r_signed;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_count;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_outValid;
   logic                 r_busy;

   logic                 w_accept;
   logic                 w_lastBit;
   logic [2*WIDTH-1:0]   w_mcandExt;
   logic [2*WIDTH-1:0]   w_term;
   logic [2*WIDTH-1:0]   w_accNext;

   // A new operation can start from IDLE, or from DONE on the very edge the
   // consumer takes the previous product, so back-to-back ops lose no cycle.
   assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept = in_valid && in_ready;

   // The multiplicand is widened once at accept time; in signed mode the
   // sign extension makes the modulo-2^(2W) partial sums come out right.
   assign w_mcandExt = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a}
                                   : {{WIDTH{1'b0}}, a};

   // r_mcand already holds mcand<<i and r_mult[0] is multiplier bit i.
   // In two's complement the top multiplier bit carries negative weight,
   // so in signed mode its partial product is subtracted instead of added.
   assign w_lastBit = (r_count == LAST_BIT);
   assign w_term    = r_mult[0] ? r_mcand : '0;
   assign w_accNext = (w_lastBit && r_signed) ? (r_acc - w_term)
                                              : (r_acc + w_term);

   // Single control FSM with all outputs registered. Operands are latched
   // on accept so later changes on a/b/signed_mode cannot disturb the op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_mcand    <= '0;
         r_mult     <= '0;
         r_signed   <= 1'b0;
         r_acc      <= '0;
         r_count    <= '0;
         r_product  <= '0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mcand  <= w_mcandExt;
                  r_mult   <= b;
                  r_signed <= signed_mode;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end

            CALC: begin
               r_acc   <= w_accNext;
               r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
               r_mult  <= {1'b0, r_mult[WIDTH-1:1]};
               r_count <= r_count + CW'(1);
               if (w_lastBit) begin
                  r_product  <= w_accNext;
                  r_outValid <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  if (w_accept) begin
                     r_mcand  <= w_mcandExt;
                     r_mult   <= b;
                     r_signed <= signed_mode;
                     r_acc    <= '0;
                     r_count  <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= CALC;
                  end else begin
                     r_state  <= IDLE;
                  end
               end
            end

            default: begin
               r_state    <= IDLE;
               r_outValid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_outValid;
   assign product   = r_product;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mpy_seq.sv
// ---------------------------------------------------------------------------
// tb_mpy_seq
//   Self-checking bench for mpy_seq. Instantiates an 8-bit and a 4-bit
//   multiplier. Expected products come from a behavioural integer model and
//   are queued when operands are accepted, then popped when out_valid rises.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mpy_seq;

   logic        clock;
   logic        rst;

   logic        inValid8, inReady8, signed8, outValid8, outReady8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        inValid4, inReady4, signed4, outValid4, outReady4, busy4;
   logic [3:0]  a4, b4;
   logic [7:0]  product4;

   int          errors;
   int          checks;
   logic [15:0] expQ8[$];
   logic [15:0] expQ4[$];

   mpy_seq #(.WIDTH(8)) dut8 (
      .clk(clock), .rst(rst),
      .in_valid(inValid8), .in_ready(inReady8),
      .a(a8), .b(b8), .signed_mode(signed8),
      .out_valid(outValid8), .out_ready(outReady8),
      .product(product8), .busy(busy8)
   );

   mpy_seq #(.WIDTH(4)) dut4 (
      .clk(clock), .rst(rst),
      .in_valid(inValid4), .in_ready(inReady4),
      .a(a4), .b(b4), .signed_mode(signed4),
      .out_valid(outValid4), .out_ready(outReady4),
      .product(product4), .busy(busy4)
   );

   // Free-running 100 MHz clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog");
   end

   // Behavioural reference: plain integer multiply of the interpreted operands
   function automatic logic [15:0] model(int w, logic [7:0] a, logic [7:0] b, bit sm);
      longint modw, va, vb, p;
      modw = longint'(1) << w;
      va = longint'(a) & (modw - 1);
      vb = longint'(b) & (modw - 1);
      if (sm && va >= modw / 2) va = va - modw;
      if (sm && vb >= modw / 2) vb = vb - modw;
      p = (va * vb) & ((longint'(1) << (2 * w)) - 1);
      return p[15:0];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] popExp(int sel);
      logic [15:0] v;
      v = 16'hxxxx;
      if (sel == 0 && expQ8.size() > 0) v = expQ8.pop_front();
      if (sel == 1 && expQ4.size() > 0) v = expQ4.pop_front();
      return v;
   endfunction

   // Wait for in_ready, present one operand set for one edge, push expectation
   task automatic applyStimulus(int sel, logic [7:0] a, logic [7:0] b, bit sm);
      int n;
      n = 0;
      while (!(sel == 0 ? inReady8 : inReady4) && n < 50) begin
         tick();
         n++;
      end
      check("acceptWait", 32'(n < 50), 32'd1);
      if (sel == 0) begin
         a8 = a; b8 = b; signed8 = sm; inValid8 = 1'b1;
         expQ8.push_back(model(8, a, b, sm));
      end else begin
         a4 = a[3:0]; b4 = b[3:0]; signed4 = sm; inValid4 = 1'b1;
         expQ4.push_back(model(4, a, b, sm));
      end
      tick();
      inValid8 = 1'b0;
      inValid4 = 1'b0;
   endtask

   // Count edges to out_valid, compare product, stall, then hand shake it off
   task automatic checkOutput(int sel, int stall, int edgesSoFar);
      int n;
      int w;
      w = (sel == 0) ? 8 : 4;
      n = edgesSoFar;
      while (!(sel == 0 ? outValid8 : outValid4) && n < 40) begin
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(w));
      check("product", 32'(sel == 0 ? product8 : {8'h00, product4}), 32'(popExp(sel)));
      for (int s = 0; s < stall; s++) tick();
      if (sel == 0) outReady8 = 1'b1; else outReady4 = 1'b1;
      tick();
      outReady8 = 1'b0;
      outReady4 = 1'b0;
      check("validDrop", 32'(sel == 0 ? outValid8 : outValid4), 32'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      inValid8 = 0; a8 = 0; b8 = 0; signed8 = 0; outReady8 = 0;
      inValid4 = 0; a4 = 0; b4 = 0; signed4 = 0; outReady4 = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] reset state");
      check("rstValid8", 32'(outValid8), 32'd0);
      check("rstBusy8", 32'(busy8), 32'd0);
      check("rstProd8", 32'(product8), 32'd0);
      check("rstReady8", 32'(inReady8), 32'd1);
      check("rstValid4", 32'(outValid4), 32'd0);
      check("rstProd4", 32'(product4), 32'd0);

      // out_ready while idle must not disturb anything
      outReady8 = 1'b1;
      tick();
      outReady8 = 1'b0;
      check("idleOutReady", 32'(outValid8), 32'd0);
      check("idleInReady", 32'(inReady8), 32'd1);

      $display("[TB] directed corner products");
      applyStimulus(0, 8'hFF, 8'hFF, 1'b0);
      check("expFE01", 32'(expQ8[0]), 32'h0000FE01);
      checkOutput(0, 0, 0);
      applyStimulus(0, 8'h80, 8'h80, 1'b1);
      checkOutput(0, 0, 0);
      check("prod4000", 32'(product8), 32'h00004000);
      applyStimulus(0, 8'hFF, 8'h7F, 1'b1);
      checkOutput(0, 1, 0);
      check("prodFF81", 32'(product8), 32'h0000FF81);
      applyStimulus(0, 8'hFF, 8'h7F, 1'b0);
      checkOutput(0, 0, 0);
      check("prod7E81", 32'(product8), 32'h00007E81);

      $display("[TB] backpressure and back-to-back accept");
      begin
         int n;
         applyStimulus(0, 8'd3, 8'd5, 1'b0);
         n = 0;
         while (!outValid8 && n < 40) begin
            tick();
            n++;
         end
         check("bpLatency", 32'(n), 32'd8);
         check("bpProduct", 32'(product8), 32'(popExp(0)));
         for (int s = 0; s < 5; s++) begin
            tick();
            check("bpHoldValid", 32'(outValid8), 32'd1);
            check("bpHoldProd", 32'(product8), 32'd15);
            check("bpHoldReady", 32'(inReady8), 32'd0);
         end
         outReady8 = 1'b1;
         inValid8 = 1'b1;
         a8 = 8'd200; b8 = 8'd100; signed8 = 1'b0;
         #1;
         check("bpSameEdgeReady", 32'(inReady8), 32'd1);
         expQ8.push_back(model(8, 8'd200, 8'd100, 1'b0));
         tick();
         outReady8 = 1'b0;
         inValid8 = 1'b0;
         check("bpValidDrop", 32'(outValid8), 32'd0);
         check("bpBusy", 32'(busy8), 32'd1);
         check("bpStaleProd", 32'(product8), 32'd15);
         checkOutput(0, 0, 0);
         check("prod4E20", 32'(product8), 32'h00004E20);
      end

      $display("[TB] mid-operation disturbance");
      applyStimulus(0, 8'h9C, 8'h35, 1'b1);
      for (int k = 0; k < 7; k++) begin
         check("midBusy", 32'(busy8), 32'd1);
         check("midReady", 32'(inReady8), 32'd0);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         signed8 = ~signed8;
         inValid8 = (k % 2 == 0);
         tick();
      end
      inValid8 = 1'b0;
      checkOutput(0, 0, 7);
      check("prodEB4C", 32'(product8), 32'h0000EB4C);

      $display("[TB] asynchronous reset mid-calc");
      applyStimulus(0, 8'd77, 8'd99, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("arstValid", 32'(outValid8), 32'd0);
      check("arstBusy", 32'(busy8), 32'd0);
      check("arstProd", 32'(product8), 32'd0);
      void'(expQ8.pop_back());
      tick();
      rst = 1'b0;
      #1;
      check("arstReady", 32'(inReady8), 32'd1);
      for (int k = 0; k < 12; k++) begin
         tick();
         check("arstNoResult", 32'(outValid8), 32'd0);
      end

      $display("[TB] 4-bit instance");
      applyStimulus(1, 8'h08, 8'h07, 1'b1);
      checkOutput(1, 0, 0);
      check("prodC8", 32'(product4), 32'h000000C8);

      $display("[TB] random regression");
      for (int sel = 0; sel < 2; sel++) begin
         for (int sm = 0; sm < 2; sm++) begin
            for (int k = 0; k < 1000; k++) begin
               applyStimulus(sel, 8'($urandom), 8'($urandom), sm[0]);
               checkOutput(sel, $urandom_range(0, 2), 0);
            end
         end
      end

      check("queue8Empty", 32'(expQ8.size()), 32'd0);
      check("queue4Empty", 32'(expQ4.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
